// File: rtl/jacobi_pivot_search.sv
// jacobi_pivot_search: streams an NxN FP32 matrix and selects the largest-magnitude strictly-upper element.
// Optional convergence flag enabled by defining JACOBI_PIVOT_CONV_EN.
module jacobi_pivot_search #(
    parameter int          N           = 3,
    parameter int          IDX_W       = 4,
    parameter logic [31:0] CONV_THRESH = 32'h3727C5AC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      pivot_val,
    output logic [IDX_W-1:0] pivot_i,
    output logic [IDX_W-1:0] pivot_j,
    output logic [31:0]      diag_ii,
    output logic [31:0]      diag_jj,
    output logic             converged,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    localparam int CNT_W = $clog2(N * N);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] row_q, col_q, best_i_q, best_j_q, pivot_i_q, pivot_j_q;
    logic [30:0]      best_mag_q;
    logic [31:0]      best_val_q, pivot_val_q, diag_ii_q, diag_jj_q;
    logic [31:0]      diag_q [DEPTH];
    logic             converged_q, conv_d, accept, last, is_nan, take;

    assign accept = (state_q == SCAN) && in_valid;
    assign last   = cnt_q == CNT_W'(N * N - 1);
    assign is_nan = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    assign take   = accept && (col_q > row_q) && !is_nan && (in_data[30:0] > best_mag_q);

`ifdef JACOBI_PIVOT_CONV_EN
    assign conv_d = best_mag_q < CONV_THRESH[30:0];
`else
    logic unused_thresh;
    assign unused_thresh = ^CONV_THRESH;
    assign conv_d = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE && start)          ? SCAN :
                  (state_q == SCAN && accept && last) ? DONE :
                  (state_q == DONE && out_ready)      ? IDLE : state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            best_mag_q  <= '0;
            best_val_q  <= '0;
            best_i_q    <= '0;
            best_j_q    <= '0;
            pivot_val_q <= '0;
            pivot_i_q   <= '0;
            pivot_j_q   <= '0;
            diag_ii_q   <= '0;
            diag_jj_q   <= '0;
            converged_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) diag_q[k] <= '0;
        end else if (state_q == IDLE && start) begin
            cnt_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            best_mag_q <= '0;
            best_val_q <= '0;
            best_i_q   <= '0;
            best_j_q   <= IDX_W'(1);
        end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            col_q <= (col_q == IDX_W'(N - 1)) ? '0 : col_q + 1'b1;
            row_q <= (col_q == IDX_W'(N - 1)) ? row_q + 1'b1 : row_q;
            if (row_q == col_q) diag_q[row_q] <= in_data;
            if (take) begin
                best_mag_q <= in_data[30:0];
                best_val_q <= in_data;
                best_i_q   <= row_q;
                best_j_q   <= col_q;
            end
            // The final beat is always diag[N-1], so it is forwarded straight into diag_jj.
            if (last) begin
                pivot_val_q <= best_val_q;
                pivot_i_q   <= best_i_q;
                pivot_j_q   <= best_j_q;
                diag_ii_q   <= diag_q[best_i_q];
                diag_jj_q   <= (best_j_q == IDX_W'(N - 1)) ? in_data : diag_q[best_j_q];
                converged_q <= conv_d;
            end
        end
    end

    assign in_ready  = state_q == SCAN;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign pivot_val = pivot_val_q;
    assign pivot_i   = pivot_i_q;
    assign pivot_j   = pivot_j_q;
    assign diag_ii   = diag_ii_q;
    assign diag_jj   = diag_jj_q;
    assign converged = converged_q;
endmodule

// File: doc/jacobi_pivot_search.md
# jacobi_pivot_search

Sequential pivot selector for one Jacobi sweep. It accepts an N×N FP32 symmetric matrix streamed row-major over a valid/ready handshake and finds the strictly-upper-triangular element with the largest magnitude. It then presents that pivot a_ij, its indices (i, j) and the diagonal pair a_ii and a_jj. It sits directly upstream of the FP32 doubling multiplier: `pivot_val` drives that multiplier's operand to form 2·a_ij for the rotation-angle path.

## Interface
- `N`, default 3: matrix dimension; legal range 2..16.
- `IDX_W`, default 4: index width; must satisfy 2^IDX_W ≥ N.
- `CONV_THRESH`, default 32'h3727C5AC (1.0e-5): FP32 convergence threshold; only used with the configuration macro.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low; all state and outputs clear immediately.
- `start`, input, 1: one-cycle pulse that begins a scan; sampled only in IDLE.
- `in_data`, input, 32: FP32 matrix element, row-major order.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block accepts an element this cycle.
- `pivot_val`, output, 32: selected a_ij, sign preserved.
- `pivot_i`, output, IDX_W: row of pivot.
- `pivot_j`, output, IDX_W: column of pivot; always greater than `pivot_i`.
- `diag_ii`, output, 32: a_ii.
- `diag_jj`, output, 32: a_jj.
- `converged`, output, 1: |pivot| < CONV_THRESH.
- `out_valid`, output, 1: result outputs are valid.
- `out_ready`, input, 1: consumer takes the result.
- `busy`, output, 1: state is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE: `start` → SCAN. On entry to SCAN, clear the element counter, row/column counters and best magnitude, and preset best index to (0,1) with value 0.
  - SCAN: `in_ready`=1. Each cycle with `in_valid`&&`in_ready` is one accepted element. Accepting the element with count N·N−1 → DONE.
  - DONE: `out_valid`=1 and all result outputs are held stable. `out_ready` → IDLE.
- Row and column counters advance per accepted element. Column wraps at N−1 to 0, and the row increments on that wrap.
- When row == col, the element is written to diagonal register array `diag[row]`.
- When col > row, the element is a pivot candidate. Elements with col < row are accepted and discarded; symmetry is not checked.
- Magnitude compare: unsigned compare of bits [30:0].
  - A candidate replaces the current best only if strictly greater, so ties keep the earliest element in row-major order.
  - NaN candidates (exp=8'hFF, mantissa≠0) are never selected.
  - ±Inf and denormals are compared as-is.
- In DONE: `diag_ii`=`diag[pivot_i]`, `diag_jj`=`diag[pivot_j]`, `pivot_val` is the raw 32-bit element.
- If every off-diagonal element is zero or NaN, the result is `pivot_val`=0, `pivot_i`=0, `pivot_j`=1.
- `start` outside IDLE is ignored, as is `start` in the same cycle as the DONE→IDLE transition.
- No arithmetic is performed on mantissas; the block only selects and compares values.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `busy`=0, `converged`=0. `pivot_val`, `pivot_i`, `pivot_j`, `diag_ii` and `diag_jj` are all 0. State is IDLE.
- `start` high at edge t0 → SCAN from t0; `in_ready`=1 in the cycle after t0.
- With in_valid held high, the last element is accepted at edge t0+N·N and `out_valid` rises after that same edge. Minimum latency from start to result is N·N cycles.
- `in_valid` gaps stall the scan with no loss of state; the element count includes only accepted beats.
- All outputs are registered, with no combinational path from inputs to outputs. `in_ready` depends only on state.
- In DONE, `in_ready`=0 and results hold for any number of cycles until `out_ready`. The handshake completes at the edge where `out_valid`&&`out_ready`; `out_valid` falls after that edge.
- Reset asserted mid-SCAN or mid-DONE: the block returns to IDLE asynchronously, partial results are discarded, and outputs take their reset values.

## Configuration
- `JACOBI_PIVOT_CONV_EN` defined: `converged` is registered on entry to DONE as ({best magnitude} < CONV_THRESH[30:0]). The downstream control stops sweeping when `converged` is 1.
- `JACOBI_PIVOT_CONV_EN` undefined: the comparator is removed, `converged` is tied to 0, and CONV_THRESH is unused.

## Test plan
- Basic selection, N=3:
  - Stimulus: rows [40800000 3F800000 C0000000], [3F800000 40000000 3F000000], [C0000000 3F000000 40400000] (4, 1, −2 / 1, 2, 0.5 / −2, 0.5, 3).
  - Required response: `pivot_val`=C0000000, i=0, j=2, `diag_ii`=40800000, `diag_jj`=40400000, `converged`=0, and `out_valid` exactly 9 cycles after start with in_valid held high.
- Tie and lower triangle:
  - Stimulus: upper elements (0,1)=3F800000, (0,2)=BF800000, (1,2)=3F800000, with lower element (2,0)=41200000.
  - Required response: i=0, j=1, `pivot_val`=3F800000; the lower-triangle value is ignored.
- Stalls and backpressure:
  - Stimulus: in_valid toggles 1/0 during the scan, and out_ready is held low for 5 cycles in DONE.
  - Required response: results identical to the no-stall run, outputs stable throughout the hold, and `start` pulsed during DONE is ignored.
- NaN and zero:
  - Stimulus: all off-diagonal elements 0 except (1,2)=7FC00000.
  - Required response: `pivot_val`=0, i=0, j=1; with `JACOBI_PIVOT_CONV_EN` defined, `converged`=1.
- Reset mid-scan:
  - Stimulus: reset low after 4 accepted elements, then release and start again.
  - Required response: outputs read 0 immediately on reset, `busy`=0, and the next full scan produces correct results.
- Convergence, with macro defined:
  - Stimulus: largest off-diagonal element is 3727C5AB, then a second run with 3727C5AC.
  - Required response: `converged`=1 for 3727C5AB and `converged`=0 for 3727C5AC.
